// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, data width and baud divider helper.
// Used by both the receiver and the transmitter stage.
package uart_pkg;

   localparam int DATA_BITS = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } uart_state_e;

   function automatic int baud_div(input int clk_mhz, input int baud);
      return (clk_mhz * 1_000_000) / baud;
   endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial line plus parallel byte/strobe outputs of the UART receiver.
// The slave side is the receiver, the master side drives RX_IN and consumes bytes.
interface uart_rx_if;
   import uart_pkg::*;

   logic                 RX_IN;
   logic [DATA_BITS-1:0] RX_DATA;
   logic                 RX_DONE;
   logic                 RX_ERR;
   logic                 RX_BUSY;

   modport master (
      output RX_IN,
      input  RX_DATA,
      input  RX_DONE,
      input  RX_ERR,
      input  RX_BUSY
   );

   modport slave (
      input  RX_IN,
      output RX_DATA,
      output RX_DONE,
      output RX_ERR,
      output RX_BUSY
   );

endinterface

// File: rtl/uart_sync_edge.sv
// Two-flop synchroniser for an asynchronous input plus a falling-edge detector.
// All stages reset to 1 so an idle-high line produces no edge out of reset.
module uart_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic async_in,
   output logic sync_out,
   output logic fall
);

   logic meta_q, meta_d;
   logic sync_q, sync_d;
   logic dly_q,  dly_d;

   always_comb begin
      meta_d = async_in;
      sync_d = meta_q;
      dly_d  = sync_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         dly_q  <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
         dly_q  <= dly_d;
      end
   end

   assign sync_out = sync_q;
   assign fall     = dly_q & ~sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling from a baud counter, one-cycle done/error strobes.
// Define UART_RX_MAJORITY_EN to replace each single sample with a 2-of-3 majority vote.
module uart_rx #(
   parameter int CLK_FREQ  = 50,
   parameter int BAUD_RATE = 115200
) (
   input logic      clk,
   input logic      rst_n,
   uart_rx_if.slave bus
);
   import uart_pkg::*;

   localparam int BAUD_CNT = baud_div(CLK_FREQ, BAUD_RATE);
   localparam int HALF_CNT = BAUD_CNT / 2;
   localparam int BIT_W    = $clog2(DATA_BITS);

   localparam logic [15:0]      BAUD_LAST = 16'(BAUD_CNT - 1);
   localparam logic [BIT_W-1:0] LAST_BIT  = BIT_W'(DATA_BITS - 1);

   logic rx_s;
   logic rx_fall;
   logic sample_bit;

   uart_state_e          state_q,    state_d;
   logic [15:0]          baud_cnt_q, baud_cnt_d;
   logic [BIT_W-1:0]     bit_cnt_q,  bit_cnt_d;
   logic [DATA_BITS-1:0] shift_q,    shift_d;
   logic [DATA_BITS-1:0] data_q,     data_d;
   logic                 done_q,     done_d;
   logic                 err_q,      err_d;

   uart_sync_edge u_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .async_in (bus.RX_IN),
      .sync_out (rx_s),
      .fall     (rx_fall)
   );

`ifdef UART_RX_MAJORITY_EN
   // Voting over target-1..target+1 delays the start decision by one clock; later
   // decisions keep the full bit period, so every decision point shifts by one.
   localparam logic [15:0] START_LAST = 16'(HALF_CNT);

   logic [1:0] hist_q, hist_d;

   always_comb begin
      hist_d     = {hist_q[0], rx_s};
      sample_bit = (hist_q[1] & hist_q[0]) | (hist_q[1] & rx_s) | (hist_q[0] & rx_s);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hist_q <= 2'b11;
      end else begin
         hist_q <= hist_d;
      end
   end
`else
   localparam logic [15:0] START_LAST = 16'(HALF_CNT - 1);

   always_comb begin
      sample_bit = rx_s;
   end
`endif

   always_comb begin
      state_d    = state_q;
      baud_cnt_d = baud_cnt_q;
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      data_d     = data_q;
      done_d     = 1'b0;
      err_d      = 1'b0;

      if (state_q != S_IDLE) begin
         baud_cnt_d = baud_cnt_q + 16'd1;
      end

      case (state_q)
         S_IDLE: begin
            if (rx_fall) begin
               state_d    = S_START;
               baud_cnt_d = 16'd0;
            end
         end
         S_START: begin
            if (baud_cnt_q == START_LAST) begin
               baud_cnt_d = 16'd0;
               bit_cnt_d  = '0;
               state_d    = sample_bit ? S_IDLE : S_DATA;
            end
         end
         S_DATA: begin
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d         = 16'd0;
               shift_d[bit_cnt_q] = sample_bit;
               bit_cnt_d          = bit_cnt_q + BIT_W'(1);
               if (bit_cnt_q == LAST_BIT) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            // Deciding at mid-stop-bit leaves half a bit to catch a back-to-back start edge.
            if (baud_cnt_q == BAUD_LAST) begin
               baud_cnt_d = 16'd0;
               state_d    = S_IDLE;
               if (sample_bit) begin
                  data_d = shift_q;
                  done_d = 1'b1;
               end else begin
                  err_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d    = S_IDLE;
            baud_cnt_d = 16'd0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         baud_cnt_q <= 16'd0;
         bit_cnt_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         baud_cnt_q <= baud_cnt_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         done_q     <= done_d;
         err_q      <= err_d;
      end
   end

   assign bus.RX_DATA = data_q;
   assign bus.RX_DONE = done_q;
   assign bus.RX_ERR  = err_q;
   assign bus.RX_BUSY = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed testbench for uart_rx at 50 MHz / 5 Mbaud (10 clocks per bit).
// Expected values are hand-derived; the glitch test expects 0x96 only with UART_RX_MAJORITY_EN.
module tb_uart_rx;

   localparam int CLK_MHZ  = 50;
   localparam int BAUD     = 5_000_000;
   localparam int BAUD_CNT = 10;
   localparam int HALF_CNT = 5;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;

   uart_rx_if bus_if ();

   uart_rx #(
      .CLK_FREQ  (CLK_MHZ),
      .BAUD_RATE (BAUD)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus_if)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   always @(posedge clk) cyc++;

   // Strobe monitor: sampled 1 time unit after each rising edge
   int         done_cnt  = 0;
   int         err_cnt   = 0;
   int         viol_cnt  = 0;
   logic [7:0] rx_bytes[$];
   int         done_cyc[$];
   logic       prev_done = 1'b0;
   logic       prev_err  = 1'b0;

   always @(posedge clk) begin
      #1;
      if (bus_if.RX_DONE === 1'b1) begin
         done_cnt++;
         rx_bytes.push_back(bus_if.RX_DATA);
         done_cyc.push_back(cyc);
      end
      if (bus_if.RX_ERR === 1'b1) err_cnt++;
      if (bus_if.RX_DONE === 1'b1 && bus_if.RX_ERR === 1'b1) viol_cnt++;
      if ((bus_if.RX_DONE === 1'b1 && prev_done) || (bus_if.RX_ERR === 1'b1 && prev_err)) viol_cnt++;
      prev_done = (bus_if.RX_DONE === 1'b1);
      prev_err  = (bus_if.RX_ERR === 1'b1);
   end

   // Drives one 10-bit frame on negedges; glitch inverts the 6th clock of each data bit
   task automatic applyStimulus(input logic [7:0] data, input logic stop_bit,
                                input bit glitch, output int start_cyc);
      logic [9:0] bits;
      bits      = {stop_bit, data, 1'b0};
      start_cyc = 0;
      for (int i = 0; i < 10; i++) begin
         for (int c = 0; c < BAUD_CNT; c++) begin
            @(negedge clk);
            if (i == 0 && c == 0) start_cyc = cyc;
            bus_if.RX_IN = bits[i] ^ (glitch && i >= 1 && i <= 8 && c == HALF_CNT);
         end
      end
   endtask

   task automatic test_reset();
      rst_n        = 1'b0;
      bus_if.RX_IN = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (bus_if.RX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL reset_data: got %h expected 00", bus_if.RX_DATA); end
      checks++;
      if (bus_if.RX_DONE !== 1'b0) begin failures++; $display("[TB] FAIL reset_done: got %b expected 0", bus_if.RX_DONE); end
      checks++;
      if (bus_if.RX_ERR !== 1'b0) begin failures++; $display("[TB] FAIL reset_err: got %b expected 0", bus_if.RX_ERR); end
      checks++;
      if (bus_if.RX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL reset_busy: got %b expected 0", bus_if.RX_BUSY); end
      rst_n = 1'b1;
      repeat (5) @(negedge clk);
   endtask

   task automatic test_single();
      int d0, e0, st, lat;
      logic [7:0] got;
      d0 = done_cnt;
      e0 = err_cnt;
      applyStimulus(8'h55, 1'b1, 1'b0, st);
      repeat (10) @(negedge clk);
      got = (rx_bytes.size() > 0) ? rx_bytes[rx_bytes.size()-1] : 8'hxx;
      lat = (done_cyc.size() > 0) ? done_cyc[done_cyc.size()-1] - st : -1;
      checks++;
      if (done_cnt - d0 != 1) begin failures++; $display("[TB] FAIL single_done_count: got %0d expected 1", done_cnt - d0); end
      checks++;
      if (got !== 8'h55) begin failures++; $display("[TB] FAIL single_byte: got %h expected 55", got); end
      checks++;
      if (bus_if.RX_DATA !== 8'h55) begin failures++; $display("[TB] FAIL single_rx_data: got %h expected 55", bus_if.RX_DATA); end
      checks++;
      if (err_cnt != e0) begin failures++; $display("[TB] FAIL single_err: got %0d expected 0", err_cnt - e0); end
      checks++;
      if (bus_if.RX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL single_busy: got %b expected 0", bus_if.RX_BUSY); end
      checks++;
      if (lat < 97 || lat > 99) begin failures++; $display("[TB] FAIL single_latency: got %0d expected 97..99", lat); end
   endtask

   task automatic test_back_to_back();
      int d0, e0, idx, st0, st1, gap;
      logic [7:0] b0, b1;
      d0  = done_cnt;
      e0  = err_cnt;
      idx = rx_bytes.size();
      applyStimulus(8'hA3, 1'b1, 1'b0, st0);
      applyStimulus(8'h0F, 1'b1, 1'b0, st1);
      repeat (10) @(negedge clk);
      b0  = (rx_bytes.size() > idx)     ? rx_bytes[idx]   : 8'hxx;
      b1  = (rx_bytes.size() > idx + 1) ? rx_bytes[idx+1] : 8'hxx;
      gap = (done_cyc.size() > idx + 1) ? done_cyc[idx+1] - done_cyc[idx] : -1;
      checks++;
      if (done_cnt - d0 != 2) begin failures++; $display("[TB] FAIL b2b_done_count: got %0d expected 2", done_cnt - d0); end
      checks++;
      if (b0 !== 8'hA3) begin failures++; $display("[TB] FAIL b2b_byte0: got %h expected a3", b0); end
      checks++;
      if (b1 !== 8'h0F) begin failures++; $display("[TB] FAIL b2b_byte1: got %h expected 0f", b1); end
      checks++;
      if (gap != 100) begin failures++; $display("[TB] FAIL b2b_gap: got %0d expected 100", gap); end
      checks++;
      if (bus_if.RX_DATA !== 8'h0F) begin failures++; $display("[TB] FAIL b2b_rx_data: got %h expected 0f", bus_if.RX_DATA); end
      checks++;
      if (err_cnt != e0) begin failures++; $display("[TB] FAIL b2b_err: got %0d expected 0", err_cnt - e0); end
   endtask

   task automatic test_glitch_reject();
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      bus_if.RX_IN = 1'b0;
      repeat (3) @(negedge clk);
      bus_if.RX_IN = 1'b1;
      @(negedge clk);
      checks++;
      if (bus_if.RX_BUSY !== 1'b1) begin failures++; $display("[TB] FAIL glitch_busy_start: got %b expected 1", bus_if.RX_BUSY); end
      repeat (20) @(negedge clk);
      checks++;
      if (bus_if.RX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL glitch_busy_idle: got %b expected 0", bus_if.RX_BUSY); end
      checks++;
      if (done_cnt != d0) begin failures++; $display("[TB] FAIL glitch_done: got %0d expected 0", done_cnt - d0); end
      checks++;
      if (err_cnt != e0) begin failures++; $display("[TB] FAIL glitch_err: got %0d expected 0", err_cnt - e0); end
      checks++;
      if (bus_if.RX_DATA !== 8'h0F) begin failures++; $display("[TB] FAIL glitch_rx_data: got %h expected 0f", bus_if.RX_DATA); end
   endtask

   task automatic test_framing_error();
      int d0, e0, st;
      d0 = done_cnt;
      e0 = err_cnt;
      applyStimulus(8'h3C, 1'b0, 1'b0, st);
      @(negedge clk);
      bus_if.RX_IN = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1) begin failures++; $display("[TB] FAIL ferr_err_count: got %0d expected 1", err_cnt - e0); end
      checks++;
      if (done_cnt != d0) begin failures++; $display("[TB] FAIL ferr_done: got %0d expected 0", done_cnt - d0); end
      checks++;
      if (bus_if.RX_DATA !== 8'h0F) begin failures++; $display("[TB] FAIL ferr_rx_data: got %h expected 0f", bus_if.RX_DATA); end
      checks++;
      if (bus_if.RX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL ferr_busy: got %b expected 0", bus_if.RX_BUSY); end
   endtask

   task automatic test_break();
      int d0, e0;
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      bus_if.RX_IN = 1'b0;
      repeat (350) @(negedge clk);
      bus_if.RX_IN = 1'b1;
      repeat (20) @(negedge clk);
      checks++;
      if (err_cnt - e0 != 1) begin failures++; $display("[TB] FAIL break_err_count: got %0d expected 1", err_cnt - e0); end
      checks++;
      if (done_cnt != d0) begin failures++; $display("[TB] FAIL break_done: got %0d expected 0", done_cnt - d0); end
      checks++;
      if (bus_if.RX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL break_busy: got %b expected 0", bus_if.RX_BUSY); end
   endtask

   task automatic test_reset_midframe();
      int d0, e0, st;
      logic [7:0] got;
      d0 = done_cnt;
      e0 = err_cnt;
      @(negedge clk);
      bus_if.RX_IN = 1'b0;
      repeat (BAUD_CNT) @(negedge clk);
      bus_if.RX_IN = 1'b1;
      repeat (45) @(negedge clk);
      checks++;
      if (bus_if.RX_BUSY !== 1'b1) begin failures++; $display("[TB] FAIL midrst_busy_before: got %b expected 1", bus_if.RX_BUSY); end
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus_if.RX_BUSY !== 1'b0) begin failures++; $display("[TB] FAIL midrst_busy_async: got %b expected 0", bus_if.RX_BUSY); end
      checks++;
      if (bus_if.RX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data_async: got %h expected 00", bus_if.RX_DATA); end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (120) @(negedge clk);
      checks++;
      if (done_cnt != d0) begin failures++; $display("[TB] FAIL midrst_no_done: got %0d expected 0", done_cnt - d0); end
      checks++;
      if (err_cnt != e0) begin failures++; $display("[TB] FAIL midrst_no_err: got %0d expected 0", err_cnt - e0); end
      checks++;
      if (bus_if.RX_DATA !== 8'h00) begin failures++; $display("[TB] FAIL midrst_data_held: got %h expected 00", bus_if.RX_DATA); end
      applyStimulus(8'h81, 1'b1, 1'b0, st);
      repeat (10) @(negedge clk);
      got = (rx_bytes.size() > 0) ? rx_bytes[rx_bytes.size()-1] : 8'hxx;
      checks++;
      if (done_cnt - d0 != 1) begin failures++; $display("[TB] FAIL midrst_done_count: got %0d expected 1", done_cnt - d0); end
      checks++;
      if (got !== 8'h81) begin failures++; $display("[TB] FAIL midrst_byte: got %h expected 81", got); end
      checks++;
      if (bus_if.RX_DATA !== 8'h81) begin failures++; $display("[TB] FAIL midrst_rx_data: got %h expected 81", bus_if.RX_DATA); end
   endtask

   task automatic test_majority();
      int d0, st;
      logic [7:0] got, exp_byte;
`ifdef UART_RX_MAJORITY_EN
      exp_byte = 8'h96;
`else
      exp_byte = 8'h69;
`endif
      d0 = done_cnt;
      applyStimulus(8'h96, 1'b1, 1'b1, st);
      repeat (10) @(negedge clk);
      got = (rx_bytes.size() > 0) ? rx_bytes[rx_bytes.size()-1] : 8'hxx;
      checks++;
      if (done_cnt - d0 != 1) begin failures++; $display("[TB] FAIL maj_done_count: got %0d expected 1", done_cnt - d0); end
      checks++;
      if (got !== exp_byte) begin failures++; $display("[TB] FAIL maj_byte: got %h expected %h", got, exp_byte); end
   endtask

   task automatic test_strobe_rules();
      checks++;
      if (viol_cnt != 0) begin failures++; $display("[TB] FAIL strobe_rules: got %0d violations expected 0", viol_cnt); end
   endtask

   initial begin
      bus_if.RX_IN = 1'b1;
      $display("[TB] uart_rx directed test start");
      test_reset();
      test_single();
      test_back_to_back();
      test_glitch_reject();
      test_framing_error();
      test_break();
      test_reset_midframe();
      test_majority();
      test_strobe_rules();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
